// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/flush controller.
// Contents: PC select encodings, the "operand unused" Tuse value, MDU FSM
// state encodings, and a helper for the Tuse/Tnew RAW hazard test.
package pipe_ctrl_pkg;

   localparam int unsigned PC_SEL_W  = 2;
   localparam int unsigned REG_ADR_W = 5;
   localparam int unsigned T_W       = 2;

   localparam logic [PC_SEL_W-1:0] PC_SEL_SEQ     = 2'd0;
   localparam logic [PC_SEL_W-1:0] PC_SEL_HANDLER = 2'd1;
   localparam logic [PC_SEL_W-1:0] PC_SEL_EPC     = 2'd2;

   // Tuse value meaning "this operand is not read"
   localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

   typedef enum logic [1:0] {
      MDU_IDLE     = 2'd0,
      MDU_BUSY_MUL = 2'd1,
      MDU_BUSY_DIV = 2'd2
   } mdu_state_t;

   // True when a producer in a later stage cannot deliver src in time for D
   function automatic logic raw_hit(
      input logic [REG_ADR_W-1:0] src,
      input logic [T_W-1:0]       tuse,
      input logic                 wr,
      input logic [REG_ADR_W-1:0] dst,
      input logic [T_W-1:0]       tnew
   );
      return (src != '0) && (tuse != TUSE_NONE) && wr && (dst == src) && (tuse < tnew);
   endfunction

endpackage

// File: rtl/mdu_busy_fsm.sv
// Busy tracker for the multi-cycle mult/div unit.
// Ports: clk, reset (sync, active-high), md_go (start strobe), md_div
// (1 = div, 0 = mult, valid with md_go), md_busy (high for exactly
// MULT_LAT or DIV_LAT cycles after the start cycle).
module mdu_busy_fsm
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10,
   parameter int unsigned CNT_W    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic md_go,
   input  logic md_div,
   output logic md_busy
);

   mdu_state_t        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;

   // State and countdown registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MDU_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Load latency-1 on start; busy ends the cycle after the count hits 0
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (md_go) begin
         if (md_div) begin
            state_nxt = MDU_BUSY_DIV;
            cnt_nxt   = CNT_W'(DIV_LAT - 1);
         end else begin
            state_nxt = MDU_BUSY_MUL;
            cnt_nxt   = CNT_W'(MULT_LAT - 1);
         end
      end else if (state != MDU_IDLE) begin
         if (cnt == '0) begin
            state_nxt = MDU_IDLE;
         end else begin
            cnt_nxt = cnt - CNT_W'(1);
         end
      end
   end

   assign md_busy = (state != MDU_IDLE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline.
// Inputs: D-stage source regs and Tuse, E/M destinations and Tnew, MDU
// start/type from E, exception request and eret from M.
// Outputs: stall, fd/de/em/mw clears, pc_sel, md_go, md_busy.
// Optional macro PIPE_PERF_CNT_EN adds stall_cnt/flush_cnt counters.
// All control outputs are combinational from inputs and MDU state.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10,
   parameter int unsigned CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  D_rs,
   input  logic [4:0]  D_rt,
   input  logic [1:0]  D_Tuse_rs,
   input  logic [1:0]  D_Tuse_rt,
   input  logic        D_md_use,
   input  logic [4:0]  E_RegAddr,
   input  logic        E_RegWrite,
   input  logic [1:0]  E_Tnew,
   input  logic [4:0]  M_RegAddr,
   input  logic        M_RegWrite,
   input  logic [1:0]  M_Tnew,
   input  logic        E_md_start,
   input  logic        E_md_div,
   input  logic        exc_req,
   input  logic        M_eret,
   output logic        stall,
   output logic        fd_clr,
   output logic        de_clr,
   output logic        em_clr,
   output logic        mw_clr,
   output logic [1:0]  pc_sel,
   output logic        md_go,
   output logic        md_busy
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   logic raw_stall;
   logic mdu_stall;

   // An exception squashes the mult/div sitting in E, so it never starts
   assign md_go = E_md_start & ~exc_req;

   mdu_busy_fsm #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT),
      .CNT_W    (CNT_W)
   ) u_mdu_busy_fsm (
      .clk     (clk),
      .reset   (reset),
      .md_go   (md_go),
      .md_div  (E_md_div),
      .md_busy (md_busy)
   );

   // Hazards forwarding cannot cover
   assign raw_stall = raw_hit(D_rs, D_Tuse_rs, E_RegWrite, E_RegAddr, E_Tnew)
                    | raw_hit(D_rs, D_Tuse_rs, M_RegWrite, M_RegAddr, M_Tnew)
                    | raw_hit(D_rt, D_Tuse_rt, E_RegWrite, E_RegAddr, E_Tnew)
                    | raw_hit(D_rt, D_Tuse_rt, M_RegWrite, M_RegAddr, M_Tnew);

   // HI/LO users wait while an op is running or just entering the MDU
   assign mdu_stall = D_md_use & (md_busy | E_md_start);

   // Flush priority: exception > eret > stall
   always_comb begin
      stall  = 1'b0;
      fd_clr = 1'b0;
      de_clr = 1'b0;
      em_clr = 1'b0;
      mw_clr = 1'b0;
      pc_sel = PC_SEL_SEQ;
      if (exc_req) begin
         fd_clr = 1'b1;
         de_clr = 1'b1;
         em_clr = 1'b1;
         mw_clr = 1'b1;
         pc_sel = PC_SEL_HANDLER;
      end else if (M_eret) begin
         fd_clr = 1'b1;
         de_clr = 1'b1;
         em_clr = 1'b1;
         pc_sel = PC_SEL_EPC;
      end else if (raw_stall | mdu_stall) begin
         stall  = 1'b1;
         de_clr = 1'b1;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   // Free-running event counters, wrap at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (exc_req | M_eret) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run against a behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  D_rs, D_rt, E_RegAddr, M_RegAddr;
   logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
   logic        D_md_use, E_RegWrite, M_RegWrite;
   logic        E_md_start, E_md_div, exc_req, M_eret;
   logic        stall, fd_clr, de_clr, em_clr, mw_clr, md_go, md_busy;
   logic [1:0]  pc_sel;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
   logic [31:0] m_stall_cnt, m_flush_cnt;
`endif

   logic [8:0]  outs;
   int          busy_rem;   // model: remaining MDU busy cycles
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .D_rs       (D_rs),
      .D_rt       (D_rt),
      .D_Tuse_rs  (D_Tuse_rs),
      .D_Tuse_rt  (D_Tuse_rt),
      .D_md_use   (D_md_use),
      .E_RegAddr  (E_RegAddr),
      .E_RegWrite (E_RegWrite),
      .E_Tnew     (E_Tnew),
      .M_RegAddr  (M_RegAddr),
      .M_RegWrite (M_RegWrite),
      .M_Tnew     (M_Tnew),
      .E_md_start (E_md_start),
      .E_md_div   (E_md_div),
      .exc_req    (exc_req),
      .M_eret     (M_eret),
      .stall      (stall),
      .fd_clr     (fd_clr),
      .de_clr     (de_clr),
      .em_clr     (em_clr),
      .mw_clr     (mw_clr),
      .pc_sel     (pc_sel),
      .md_go      (md_go),
      .md_busy    (md_busy)
`ifdef PIPE_PERF_CNT_EN
      ,
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
`endif
   );

   assign outs = {stall, fd_clr, de_clr, em_clr, mw_clr, pc_sel, md_go, md_busy};

   // Does a producer still owe src later than D needs it?
   function automatic logic late_operand(input logic [4:0] src, input logic [1:0] tuse);
      if (src == 5'd0 || tuse == 2'd3) return 1'b0;
      if (E_RegWrite && E_RegAddr == src && int'(tuse) < int'(E_Tnew)) return 1'b1;
      if (M_RegWrite && M_RegAddr == src && int'(tuse) < int'(M_Tnew)) return 1'b1;
      return 1'b0;
   endfunction

   // Expected {stall,fd,de,em,mw,pc_sel,md_go,md_busy} for current inputs
   function automatic logic [8:0] exp_outs();
      logic st, go, busy;
      busy = (busy_rem > 0);
      go   = E_md_start && !exc_req;
      st   = late_operand(D_rs, D_Tuse_rs) || late_operand(D_rt, D_Tuse_rt)
             || (D_md_use && (busy || E_md_start));
      if (exc_req)     return {1'b0, 4'b1111, 2'd1, 1'b0, busy};
      else if (M_eret) return {1'b0, 4'b1110, 2'd2, go, busy};
      else             return {st, 1'b0, st, 2'b00, 2'd0, go, busy};
   endfunction

   // Advance one clock and the model; inputs change 1 ns after the edge
   task automatic tick();
`ifdef PIPE_PERF_CNT_EN
      logic [8:0] e;
`endif
      @(posedge clk);
`ifdef PIPE_PERF_CNT_EN
      e = exp_outs();
      if (reset) begin
         m_stall_cnt = '0;
         m_flush_cnt = '0;
      end else begin
         if (e[8]) m_stall_cnt = m_stall_cnt + 32'd1;
         if (exc_req || M_eret) m_flush_cnt = m_flush_cnt + 32'd1;
      end
`endif
      if (reset) busy_rem = 0;
      else if (E_md_start && !exc_req) busy_rem = E_md_div ? 10 : 5;
      else if (busy_rem > 0) busy_rem--;
      #1;
   endtask

   task automatic quiet();
      D_rs = '0; D_rt = '0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_md_use = 1'b0;
      E_RegAddr = '0; E_RegWrite = 1'b0; E_Tnew = '0;
      M_RegAddr = '0; M_RegWrite = 1'b0; M_Tnew = '0;
      E_md_start = 1'b0; E_md_div = 1'b0; exc_req = 1'b0; M_eret = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; quiet();
      tick(); tick();
      reset = 1'b0;
      @(negedge clk); checks++;
      if (outs !== 9'b0) begin errors++; $display("FAIL reset_outs got %b exp %b", outs, 9'b0); end
      tick();
   endtask

   task automatic test_raw();
      quiet();
      E_RegWrite = 1'b1; E_RegAddr = 5'd1; E_Tnew = 2'd2; D_rs = 5'd1; D_Tuse_rs = 2'd1;
      @(negedge clk); checks++;
      if (outs !== 9'b101000000) begin errors++; $display("FAIL raw_lw_use got %b exp %b", outs, 9'b101000000); end
      tick();
      E_RegWrite = 1'b0; M_RegWrite = 1'b1; M_RegAddr = 5'd1; M_Tnew = 2'd1;
      @(negedge clk); checks++;
      if (outs !== 9'b0) begin errors++; $display("FAIL raw_resolved got %b exp %b", outs, 9'b0); end
      tick();
      quiet();
      M_RegWrite = 1'b1; M_RegAddr = 5'd7; M_Tnew = 2'd1; D_rt = 5'd7; D_Tuse_rt = 2'd0;
      @(negedge clk); checks++;
      if (outs !== 9'b101000000) begin errors++; $display("FAIL raw_rt_m got %b exp %b", outs, 9'b101000000); end
      D_Tuse_rt = 2'd3;
      @(negedge clk); checks++;
      if (outs !== 9'b0) begin errors++; $display("FAIL raw_tuse_none got %b exp %b", outs, 9'b0); end
      tick();
   endtask

   task automatic test_zero_reg();
      quiet();
      E_RegWrite = 1'b1; E_RegAddr = 5'd0; E_Tnew = 2'd2;
      D_rs = 5'd0; D_Tuse_rs = 2'd0; D_rt = 5'd0; D_Tuse_rt = 2'd0;
      @(negedge clk); checks++;
      if (outs !== 9'b0) begin errors++; $display("FAIL zero_reg got %b exp %b", outs, 9'b0); end
      tick();
   endtask

   task automatic test_mult();
      int n_go = 0, n_busy = 0, n_stall = 0;
      quiet();
      E_md_start = 1'b1; E_md_div = 1'b0; D_md_use = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         n_go += int'(md_go); n_busy += int'(md_busy); n_stall += int'(stall);
         tick();
         E_md_start = 1'b0;
      end
      checks++;
      if (n_go != 1) begin errors++; $display("FAIL mult_go got %0d exp 1", n_go); end
      checks++;
      if (n_busy != 5) begin errors++; $display("FAIL mult_busy got %0d exp 5", n_busy); end
      checks++;
      if (n_stall != 6) begin errors++; $display("FAIL mult_stall got %0d exp 6", n_stall); end
      quiet();
   endtask

   task automatic test_div_exc();
      int n_busy = 0;
      quiet();
      E_md_start = 1'b1; E_md_div = 1'b1;
      tick();
      quiet();
      @(negedge clk); n_busy += int'(md_busy);
      tick();
      exc_req = 1'b1;
      @(negedge clk); n_busy += int'(md_busy); checks++;
      if (outs !== 9'b011110101) begin errors++; $display("FAIL div_exc_flush got %b exp %b", outs, 9'b011110101); end
      tick();
      exc_req = 1'b0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk); n_busy += int'(md_busy);
         tick();
      end
      checks++;
      if (n_busy != 10) begin errors++; $display("FAIL div_busy got %0d exp 10", n_busy); end
   endtask

   task automatic test_exc_start();
      quiet();
      exc_req = 1'b1; E_md_start = 1'b1;
      @(negedge clk); checks++;
      if (outs !== 9'b011110100) begin errors++; $display("FAIL exc_start got %b exp %b", outs, 9'b011110100); end
      tick();
      quiet();
      @(negedge clk); checks++;
      if (md_busy !== 1'b0) begin errors++; $display("FAIL exc_start_busy got %b exp 0", md_busy); end
      tick();
   endtask

   task automatic test_exc_eret();
      quiet();
      exc_req = 1'b1; M_eret = 1'b1;
      @(negedge clk); checks++;
      if (outs !== 9'b011110100) begin errors++; $display("FAIL exc_eret got %b exp %b", outs, 9'b011110100); end
      exc_req = 1'b0;
      @(negedge clk); checks++;
      if (outs !== 9'b011101000) begin errors++; $display("FAIL eret_only got %b exp %b", outs, 9'b011101000); end
      tick();
      quiet();
   endtask

   task automatic test_reset_mid_div();
      quiet();
      E_md_start = 1'b1; E_md_div = 1'b1;
      tick();
      quiet();
      tick(); tick(); tick();
      @(negedge clk); checks++;
      if (md_busy !== 1'b1) begin errors++; $display("FAIL mid_div_busy got %b exp 1", md_busy); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk); checks++;
      if (outs !== 9'b0) begin errors++; $display("FAIL reset_mid_div got %b exp %b", outs, 9'b0); end
      tick();
   endtask

   task automatic test_random();
      logic [8:0] e;
      for (int c = 0; c < 3000; c++) begin
         D_rs       = 5'($urandom_range(0, 3));
         D_rt       = 5'($urandom_range(0, 3));
         D_Tuse_rs  = 2'($urandom_range(0, 3));
         D_Tuse_rt  = 2'($urandom_range(0, 3));
         D_md_use   = ($urandom_range(0, 2) == 0);
         E_RegAddr  = 5'($urandom_range(0, 3));
         E_RegWrite = 1'($urandom);
         E_Tnew     = 2'($urandom_range(0, 3));
         M_RegAddr  = 5'($urandom_range(0, 3));
         M_RegWrite = 1'($urandom);
         M_Tnew     = 2'($urandom_range(0, 3));
         E_md_start = ($urandom_range(0, 7) == 0);
         E_md_div   = 1'($urandom);
         exc_req    = ($urandom_range(0, 15) == 0);
         M_eret     = ($urandom_range(0, 15) == 0);
         reset      = ($urandom_range(0, 199) == 0);
         @(negedge clk);
         e = exp_outs();
         checks++;
         if (outs !== e) begin
            errors++;
            $display("FAIL random_outs cycle %0d got %b exp %b", c, outs, e);
         end
`ifdef PIPE_PERF_CNT_EN
         checks++;
         if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
            errors++;
            $display("FAIL perf_cnt cycle %0d got %0d/%0d exp %0d/%0d",
                     c, stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
         end
`endif
         tick();
      end
      reset = 1'b0;
      quiet();
   endtask

   initial begin
      busy_rem = 0;
`ifdef PIPE_PERF_CNT_EN
      m_stall_cnt = '0;
      m_flush_cnt = '0;
`endif
      reset = 1'b1;
      quiet();
      #1;
      test_reset();
      test_raw();
      test_zero_reg();
      test_mult();
      test_div_exc();
      test_exc_start();
      test_exc_eret();
      test_reset_mid_div();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the five-stage MIPS pipeline (F/D, D/E, E/M, M/W registers).
- Detects Tuse/Tnew RAW hazards that forwarding cannot cover.
- Sequences the multi-cycle mult/div unit (MDU) through an internal busy FSM.
- Issues flush and PC-redirect commands on exceptions/interrupts and eret committed in M.
- Drives only enables/clears/selects; no datapath values pass through it.

Parameters:
MULT_LAT, 5, busy cycles for mult/multu after issue
DIV_LAT, 10, busy cycles for div/divu after issue
CNT_W, 4, MDU countdown width; must hold max(MULT_LAT, DIV_LAT)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
D_rs  in  5  rs address of instr in D
D_rt  in  5  rt address of instr in D
D_Tuse_rs  in  2  cycles until rs needed (3 = unused)
D_Tuse_rt  in  2  cycles until rt needed (3 = unused)
D_md_use  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
E_RegAddr  in  5  dest in E
E_RegWrite  in  1  E writes GPR
E_Tnew  in  2  cycles until E result ready
M_RegAddr  in  5  dest in M
M_RegWrite  in  1  M writes GPR
M_Tnew  in  2  cycles until M result ready
E_md_start  in  1  mult/div present in E this cycle
E_md_div  in  1  1 = div/divu, 0 = mult/multu (valid with E_md_start)
exc_req  in  1  CP0 takes exception/interrupt on M instr
M_eret  in  1  eret in M
stall  out  1  hold PC and F/D; clear D/E
fd_clr  out  1  clear F/D
de_clr  out  1  clear D/E
em_clr  out  1  clear E/M
mw_clr  out  1  clear M/W
pc_sel  out  2  0 = sequential/branch, 1 = handler 0x4180, 2 = EPC
md_go  out  1  MDU start strobe
md_busy  out  1  MDU busy

Behaviour:
- Reset: FSM IDLE, counter 0. All outputs 0 (md_busy=0, pc_sel=0) in the cycle after a reset edge. Reset mid-operation abandons any MDU operation.
- RAW stall (combinational):
  - Stall on rs if D_rs != 0, and either (E_RegWrite & E_RegAddr == D_rs & D_Tuse_rs < E_Tnew) or (M_RegWrite & M_RegAddr == D_rs & D_Tuse_rs < M_Tnew).
  - Same rule for rt.
  - Tuse = 3 never stalls.
- MDU FSM: states IDLE, BUSY_MUL, BUSY_DIV.
  - md_go = E_md_start & ~exc_req.
  - On md_go: counter loads MULT_LAT-1 or DIV_LAT-1; state becomes BUSY_MUL or BUSY_DIV.
  - In a BUSY state: counter decrements each cycle; return to IDLE the cycle after counter reaches 0.
  - md_busy = (state != IDLE). A mult gives exactly MULT_LAT busy cycles; a div gives exactly DIV_LAT.
  - An exception does not cancel an operation already in BUSY.
- MDU stall: D_md_use & (md_busy | E_md_start).
- stall = RAW stall | MDU stall. When stall=1: de_clr=1, fd_clr=0.
- Exception (exc_req=1, priority over everything):
  - fd_clr=de_clr=em_clr=mw_clr=1, pc_sel=1, stall forced 0.
  - M_eret is ignored in the same cycle.
- eret (M_eret=1, exc_req=0): fd_clr=de_clr=em_clr=1, mw_clr=0, pc_sel=2, stall forced 0.
- Outputs are combinational from inputs and registered state. Single-cycle latency: a hazard asserts stall in the same cycle.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle stall=1.
  - flush_cnt increments each cycle exc_req|M_eret.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and logic absent; the rest of the behaviour is unchanged.

Decomposition:
- Shared package pipe_ctrl_pkg: PC_SEL_SEQ/HANDLER/EPC constants, TUSE_NONE=3, MDU state encodings.
- One sub-module, mdu_busy_fsm: FSM + countdown; outputs md_busy.
- Hazard compare and flush priority stay in the top.

Test Plan:
- lw $1 in E (E_Tnew=2), D addu uses $1 (Tuse=1) -> stall=1, de_clr=1 for 1 cycle; next cycle (M_Tnew=1) stall=0.
- E_md_start, E_md_div=0, then D_md_use=1 held -> md_go pulse; md_busy high exactly 5 cycles; stall high 6 cycles (start cycle + busy).
- div issued, exc_req asserted 2 cycles later -> md_busy remains high the full 10 cycles; flush outputs all 1, pc_sel=1.
- exc_req=1 together with E_md_start=1 -> md_go=0, md_busy stays 0.
- exc_req=1 and M_eret=1 simultaneously -> pc_sel=1, mw_clr=1. M_eret alone -> pc_sel=2, mw_clr=0.
- reset asserted mid-div (counter=6) -> next cycle md_busy=0, all outputs 0. D_rs=0 with matching E_RegAddr=0 -> no stall.
